// File: rtl/topk_drain_if.sv
// Streaming bus for topk_drain: input beat channel plus drained output channel.
interface topk_drain_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/topk_drain.sv
// Retains the DEPTH largest unsigned values seen and, on request, emits them
// largest-first as a packet terminated by out_last.
module topk_drain #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  topk_drain_if.slave                  bus,
  input  logic                         drain,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_DRAIN   = 1'b1
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] ent     [DEPTH];
  logic [DATA_WIDTH-1:0] ins_ent [DEPTH];
  logic [DEPTH-1:0]      ge;
  logic                  accept;
  logic                  full;
  logic                  do_ins;
  logic [CNT_W-1:0]      cnt_acc;

  // Sorted insert: ge marks held entries that stay above the new value,
  // so equal values land after existing ones.
  always_comb begin
    accept  = (state == S_COLLECT) && bus.in_valid;
    full    = (count == CNT_W'(DEPTH));
    do_ins  = accept && (!full || (bus.in_data > ent[DEPTH-1]));
    cnt_acc = (accept && !full) ? count + CNT_W'(1) : count;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ge[i] = (CNT_W'(i) < count) && (ent[i] >= bus.in_data);
    end
    ins_ent[0] = ge[0] ? ent[0] : bus.in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (ge[i]) begin
        ins_ent[i] = ent[i];
      end else if (ge[i-1]) begin
        ins_ent[i] = bus.in_data;
      end else begin
        ins_ent[i] = ent[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_COLLECT;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent[i] <= '0;
      end
    end else begin
      case (state)
        S_COLLECT: begin
          if (do_ins) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
              ent[i] <= ins_ent[i];
            end
          end
          count <= cnt_acc;
          if (drain && (cnt_acc != '0)) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Entries beyond count are always zero, so the last emit leaves the array clear.
          if (bus.out_ready) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
              ent[i] <= ent[i+1];
            end
            ent[DEPTH-1] <= '0;
            count        <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              state <= S_COLLECT;
            end
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_COLLECT);
  assign bus.out_valid = (state == S_DRAIN);
  assign bus.out_data  = ent[0];
  assign bus.out_last  = (state == S_DRAIN) && (count == CNT_W'(1));

endmodule

// File: tb/tb_topk_drain.sv
// Directed bench for topk_drain: a reference top-k model fills an expected-beat
// queue at each drain request and a negedge monitor pops it on every handshake.
module tb_topk_drain;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          drain;
  logic [CW-1:0] count;

  topk_drain_if #(.DATA_WIDTH(DW)) bus ();

  topk_drain #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave),
    .drain  (drain),
    .count  (count)
  );

  always #5 clk = ~clk;

  beat_t         exp_q[$];
  logic [DW-1:0] mdl[$];
  beat_t         cur;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    chk("in_ready_collect", 64'(bus.in_ready), 64'd1);
    cyc();
    bus.in_valid = 1'b0;
    mdl.push_back(d);
    n = (mdl.size() < int'(DEPTH)) ? mdl.size() : int'(DEPTH);
    chk("count_after_push", 64'(count), 64'(n));
  endtask

  // Reference: largest DEPTH of everything accepted, emitted descending.
  task automatic load_expected();
    logic [DW-1:0] s[$];
    int n;
    s = mdl;
    s.rsort();
    n = (s.size() < int'(DEPTH)) ? s.size() : int'(DEPTH);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{data: s[k], last: (k == n - 1)});
    end
    mdl.delete();
  endtask

  task automatic do_drain();
    load_expected();
    drain = 1'b1;
    cyc();
    drain = 1'b0;
  endtask

  task automatic wait_empty(input int want_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      cyc();
      n++;
    end
    chk("drain_cycles", 64'(n), 64'(want_cycles));
    chk("in_ready_after_drain", 64'(bus.in_ready), 64'd1);
    chk("out_valid_after_drain", 64'(bus.out_valid), 64'd0);
    chk("count_after_drain", 64'(count), 64'd0);
  endtask

  // Scoreboard monitor: every output handshake must match the next expected beat.
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(bus.out_valid), 64'd0);
      end else begin
        chk("count_vs_pending", 64'(count), 64'(exp_q.size()));
        cur = exp_q.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(cur.data));
        chk("out_last", 64'(bus.out_last), 64'(cur.last));
      end
    end
  end

  initial begin
    resetn        = 1'b0;
    drain         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_count", 64'(count), 64'd0);

    // Basic top-4 with discard of the overflow minimum
    bus.out_ready = 1'b1;
    push(32'd5); push(32'd9); push(32'd2); push(32'd7); push(32'd1); push(32'd8);
    do_drain();
    chk("drain_latency_valid", 64'(bus.out_valid), 64'd1);
    chk("drain_in_ready_low", 64'(bus.in_ready), 64'd0);
    wait_empty(4);

    // Equal values
    push(32'd3); push(32'd3);
    do_drain();
    wait_empty(2);

    // Drain with nothing held is ignored
    drain = 1'b1;
    cyc();
    drain = 1'b0;
    chk("empty_drain_valid", 64'(bus.out_valid), 64'd0);
    chk("empty_drain_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    chk("empty_drain_valid2", 64'(bus.out_valid), 64'd0);

    // Beat and drain in the same cycle
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd6;
    drain        = 1'b1;
    mdl.push_back(32'd6);
    load_expected();
    cyc();
    bus.in_valid = 1'b0;
    drain        = 1'b0;
    chk("same_cycle_valid", 64'(bus.out_valid), 64'd1);
    chk("same_cycle_data", 64'(bus.out_data), 64'd6);
    chk("same_cycle_last", 64'(bus.out_last), 64'd1);
    wait_empty(1);

    // Full-array replacement, strict-greater rule and unsigned MSB
    push(32'd10); push(32'd20); push(32'd30); push(32'd40);
    push(32'd15); push(32'd15); push(32'd5); push(32'hFFFF_FFF0);
    do_drain();
    wait_empty(4);

    // Backpressure hold; input and drain ignored while draining
    bus.out_ready = 1'b0;
    push(32'd9); push(32'd8);
    do_drain();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd99;
    drain        = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_data", 64'(bus.out_data), 64'd9);
      chk("hold_count", 64'(count), 64'd2);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      cyc();
    end
    bus.in_valid  = 1'b0;
    drain         = 1'b0;
    bus.out_ready = 1'b1;
    wait_empty(2);

    // Reset in the middle of a drain
    bus.out_ready = 1'b0;
    push(32'd4); push(32'd2);
    do_drain();
    chk("pre_reset_data", 64'(bus.out_data), 64'd4);
    bus.out_ready = 1'b1;
    cyc();
    chk("pre_reset_count", 64'(count), 64'd1);
    resetn        = 1'b0;
    bus.out_ready = 1'b0;
    cyc();
    exp_q.delete();
    resetn = 1'b1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_out_data", 64'(bus.out_data), 64'd0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("post_rst_quiet", 64'(bus.out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/topk_drain.md
TOPK_DRAIN -- requirements
Module: topk_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of every data value (unsigned).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of largest values retained (legal range 2..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning in_data holds a valid beat.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-007 SHALL have port in_data, input, DATA_WIDTH, the incoming value.
REQ-008 SHALL have port drain, input, 1, a request to emit retained values.
REQ-009 SHALL have port out_valid, output, 1, meaning out_data holds a valid beat.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts out_data this cycle.
REQ-011 SHALL have port out_data, output, DATA_WIDTH, the emitted value.
REQ-012 SHALL have port out_last, output, 1, meaning the final beat of a drain.
REQ-013 SHALL have port count, output, $clog2(DEPTH+1), the number of values currently held.

Function
REQ-014 SHALL keep a DEPTH-entry register array sorted descending (entry 0 largest) plus count, in two states: COLLECT and DRAIN.
REQ-015 SHALL drive in_ready=1 in COLLECT and 0 in DRAIN; a beat is accepted when in_valid && in_ready.
REQ-016 SHALL, on acceptance with count<DEPTH, insert in_data at its sorted position (after existing equal entries), shift lower entries down one, and increment count.
REQ-017 SHALL, on acceptance with count==DEPTH, insert in_data and drop the smallest entry only if in_data is strictly greater than entry DEPTH-1; otherwise discard it; count stays DEPTH.
REQ-018 SHALL compare values as unsigned, full DATA_WIDTH.
REQ-019 SHALL, when drain is high in COLLECT, enter DRAIN on the next edge if count after this cycle's acceptance is nonzero; a beat accepted in the same cycle as drain is included.
REQ-020 SHALL ignore drain when count after this cycle's acceptance is zero; the block stays in COLLECT.
REQ-021 SHALL ignore drain while in DRAIN.
REQ-022 SHALL drive out_valid=1 throughout DRAIN and 0 in COLLECT; out_data=entry 0; out_last=1 when count==1.
REQ-023 SHALL, on out_valid && out_ready, shift entries up one (vacated entry set to 0) and decrement count.
REQ-024 SHALL return to COLLECT on the edge completing the out_last handshake, with count=0 and all entries 0.
REQ-025 SHALL hold out_data, out_last and count stable while out_valid && !out_ready.
REQ-026 SHALL have one-cycle latency from drain sampled to out_valid asserted; no idle cycles between drain beats when out_ready is held high.

Reset
REQ-027 SHALL, while resetn is low at a rising edge, set state=COLLECT, count=0, all entries 0; inputs are ignored that cycle.
REQ-028 SHALL, the cycle after reset, present in_ready=1, out_valid=0, out_last=0, out_data=0, count=0.
REQ-029 SHALL abandon any drain in progress when reset is applied; no further out_valid until a new drain.

Verification
REQ-030 SHALL cover: DEPTH=4, accept 5,9,2,7,1,8, then drain with out_ready=1 -> out_data 9,8,7,5 on consecutive cycles, out_last only on 5, count 4->0, then in_ready=1.
REQ-031 SHALL cover: accept 3,3, drain -> out_data 3,3; out_last on second beat; then COLLECT.
REQ-032 SHALL cover: drain pulse with count=0 and in_valid=0 -> out_valid stays 0, in_ready stays 1.
REQ-033 SHALL cover: in_valid=1 with in_data=6 and drain in the same cycle with count=0 -> next cycle out_valid=1, out_data=6, out_last=1.
REQ-034 SHALL cover: in DRAIN holding 9,8, out_ready=0 for 3 cycles -> out_data=9, count=2 held; out_ready=1 -> 9 then 8 with out_last.
REQ-035 SHALL cover: resetn low for one cycle after first drain beat -> next cycle out_valid=0, count=0, in_ready=1, out_data=0.
